// File: rtl/sha_msg_sched.sv
// SHA-256 message schedule expander: takes a 16-word block, produces W[0:63].
// Shares one expander across WORDS_PER_CYCLE chained word slices per clock.
module sha_msg_sched #(
    parameter int WORDS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:15][31:0] W_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:63][31:0] W_out,
    output logic              busy
);

    localparam int         WPC  = WORDS_PER_CYCLE;
    localparam int         EXTN = 16 + WPC;
    localparam logic [6:0] STEP = 7'(WORDS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        HOLD
    } state_e;

    state_e            state_q, state_d;
    logic [6:0]        idx_q, idx_d;
    logic [0:15][31:0] win_q, win_d;
    logic [0:63][31:0] w_out_q, w_out_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic [0:EXTN-1][31:0] ext;
    logic              take;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Sliding window of the last 16 words; new words chain within the cycle.
    always_comb begin
        ext = '0;
        for (int i = 0; i < 16; i++) begin
            ext[i] = win_q[i];
        end
        for (int k = 0; k < WPC; k++) begin
            ext[16+k] = sig1(ext[14+k]) + ext[9+k]
                      + sig0(ext[1+k]) + ext[k];
        end
    end

    assign in_ready = (state_q == IDLE)
                    | ((state_q == HOLD) & out_ready);
    assign take     = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        win_d       = win_q;
        w_out_d     = w_out_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        unique case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            EXPAND: begin
                for (int k = 0; k < WPC; k++) begin
                    w_out_d[idx_q[5:0] + 6'(k)] = ext[16+k];
                end
                for (int i = 0; i < 16; i++) begin
                    win_d[i] = ext[WPC+i];
                end
                idx_d = idx_q + STEP;
                if (idx_d == 7'd64) begin
                    state_d     = HOLD;
                    out_valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A load from IDLE or a back-to-back load from HOLD overrides the above.
        if (take) begin
            state_d     = EXPAND;
            idx_d       = 7'd16;
            win_d       = W_in;
            out_valid_d = 1'b0;
            busy_d      = 1'b1;
            w_out_d     = '0;
            for (int i = 0; i < 16; i++) begin
                w_out_d[i] = W_in[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= 7'd16;
            win_q       <= '0;
            w_out_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            win_q       <= win_d;
            w_out_q     <= w_out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign W_out     = w_out_q;

endmodule

// File: tb/tb_sha_msg_sched.sv
// Bench for sha_msg_sched: random and directed blocks against a plain
// array-based schedule model, checked by a decoupled scoreboard monitor.
module tb_sha_msg_sched;

    localparam int WPC = 4;
    localparam int L   = 48 / WPC;

    typedef logic [0:15][31:0] blk_t;
    typedef logic [0:63][31:0] sch_t;

    logic clk;
    logic reset;
    logic in_valid;
    logic in_ready;
    blk_t W_in;
    logic out_valid;
    logic out_ready;
    sch_t W_out;
    logic busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    sch_t exp_q[$];
    int   acc_q[$];
    logic pend;
    logic ov_prev;
    logic rdy_prev;
    sch_t w_prev;

    sha_msg_sched #(.WORDS_PER_CYCLE(WPC)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .W_in(W_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .W_out(W_out),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic sch_t model(input blk_t b);
        logic [31:0] w[0:63];
        logic [31:0] s0;
        logic [31:0] s1;
        sch_t s;
        for (int i = 0; i < 16; i++) w[i] = b[i];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        for (int i = 0; i < 64; i++) s[i] = w[i];
        return s;
    endfunction

    function automatic blk_t rand_blk();
        blk_t b;
        for (int i = 0; i < 16; i++) b[i] = $urandom;
        return b;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s", nm);
    endtask

    task automatic chk_sched(input sch_t e);
        int fi;
        checks++;
        if (W_out !== e) begin
            errors++;
            fi = -1;
            for (int i = 0; i < 64; i++)
                if (fi < 0 && W_out[i] !== e[i]) fi = i;
            if (fi >= 0)
                $display("FAIL sched word %0d got=%h exp=%h",
                         fi, W_out[fi], e[fi]);
            else
                $display("FAIL sched contains x/z");
        end
    endtask

    // Scoreboard monitor: samples on the falling edge.
    always @(negedge clk) begin
        int a;
        if (!reset) begin
            exp_q.delete();
            acc_q.delete();
            pend     = 1'b0;
            ov_prev  = 1'b0;
            rdy_prev = 1'b0;
        end else begin
            chk("busy", busy, pend);
            chk("in_ready", in_ready, !pend || (out_valid && out_ready));
            if (ov_prev && !rdy_prev)
                chk("hold_stable", out_valid && (W_out === w_prev), 1'b1);
            if (out_valid && !ov_prev) begin
                if (acc_q.size() == 0) fail("out_valid_without_accept");
                else begin
                    a = acc_q.pop_front();
                    chk("latency", cyc - a, L);
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) fail("unexpected_output");
                else chk_sched(exp_q.pop_front());
            end
            if (out_valid && out_ready) pend = 1'b0;
            if (in_valid && in_ready) pend = 1'b1;
            ov_prev  = out_valid;
            rdy_prev = out_ready;
            w_prev   = W_out;
        end
    end

    task automatic send(input blk_t b, input bit rnd, output bit b2b);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        b2b = 1'b0;
        W_in = b;
        in_valid = 1'b1;
        while (n < 300 && !ok) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else begin
                n++;
                if (rnd) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        end
        if (!ok) fail("accept_timeout");
        else begin
            exp_q.push_back(model(b));
            acc_q.push_back(cyc + 1);
            b2b = out_valid;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_ov();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 300);
        if (!out_valid) fail("out_valid_timeout");
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) fail("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        blk_t b;
        bit   b2b;
        int   cnt;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        W_in      = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wout_zero", |W_out, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        #1 chk("rst_in_ready", in_ready, 1'b1);

        // Known first expanded words
        out_ready = 1'b1;
        b = '0;
        b[0]  = 32'h87027980;
        b[15] = 32'd24;
        send(b, 1'b0, b2b);
        wait_ov();
        chk("w16", W_out[16], 32'h87027980);
        chk("w17", W_out[17], 32'h000F0000);
        drain();

        // "abc" block
        b = '0;
        b[0]  = 32'h61626380;
        b[15] = 32'h18;
        send(b, 1'b0, b2b);
        drain();

        // All-zero block: in_ready low for exactly L cycles
        send('0, 1'b0, b2b);
        cnt = 0;
        do begin
            @(negedge clk);
            if (!in_ready) cnt++;
        end while (!in_ready && cnt < 300);
        chk("busy_window", cnt, L);
        @(posedge clk);
        #1;
        drain();

        // Stall in HOLD with a pending block
        out_ready = 1'b0;
        send(rand_blk(), 1'b0, b2b);
        wait_ov();
        @(posedge clk);
        #1;
        b = rand_blk();
        W_in = b;
        in_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_out_valid", out_valid, 1'b1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(b, 1'b0, b2b);
        chk("stall_b2b", b2b, 1'b1);
        drain();

        // Back-to-back with out_ready high
        send(rand_blk(), 1'b0, b2b);
        send(rand_blk(), 1'b0, b2b);
        chk("b2b_second", b2b, 1'b1);
        send(rand_blk(), 1'b0, b2b);
        chk("b2b_third", b2b, 1'b1);
        drain();

        // Random blocks, random gaps and backpressure
        repeat (8) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1 out_ready = 1'($urandom_range(0, 1));
            end
            send(rand_blk(), 1'b1, b2b);
        end
        drain();

        // Reset mid-expand
        send(rand_blk(), 1'b0, b2b);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("midexp_out_valid", out_valid, 1'b0);
        chk("midexp_busy", busy, 1'b0);
        chk("midexp_wout_zero", |W_out, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        send(rand_blk(), 1'b0, b2b);
        drain();

        // Reset mid-hold
        out_ready = 1'b0;
        send(rand_blk(), 1'b0, b2b);
        wait_ov();
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("midhold_out_valid", out_valid, 1'b0);
        chk("midhold_wout_zero", |W_out, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        out_ready = 1'b1;
        send(rand_blk(), 1'b0, b2b);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
